// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the data memory with locked port-1 bursts,
// address range/alignment checking and registered read data with valid/error.
module dmem_arbiter #(
    parameter int MEM_AW    = 14,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_adr,
    input  logic [31:0]       p0_wd,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rd,
    output logic              p0_err,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_adr,
    input  logic [31:0]       p1_wd,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rd,
    output logic              p1_err,
    output logic [MEM_AW-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam logic [7:0] MAXB  = 8'(MAX_BURST);

    logic [0:0]  st;
    logic        last;
    logic [7:0]  bcnt;
    logic        hold;
    logic        eff_last;
    logic        bad;
    logic        win_we;
    logic [31:0] win_adr;

    always_comb begin
        hold     = (st == BURST) && p1_req && p1_lock && (bcnt < MAXB);
        // Inside a burst the round-robin pointer is treated as "port 1 was last".
        eff_last = (st == BURST) ? 1'b1 : last;
        p0_gnt   = 1'b0;
        p1_gnt   = 1'b0;
        if (!rst) begin
            if (hold) begin
                p1_gnt = 1'b1;
            end else if (p0_req && p1_req) begin
                p0_gnt = eff_last;
                p1_gnt = ~eff_last;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
        p0_stall = p0_req & ~p0_gnt;
    end

    always_comb begin
        win_adr = p1_gnt ? p1_adr : p0_adr;
        win_we  = p1_gnt ? p1_we  : p0_we;
        mem_wd  = p1_gnt ? p1_wd  : p0_wd;
        mem_a   = win_adr[MEM_AW+1:2];
        bad     = (win_adr[1:0] != 2'b00) || (win_adr[31:MEM_AW+2] != '0);
        mem_we  = (p0_gnt | p1_gnt) & win_we & ~bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ARB;
            last      <= 1'b1;
            bcnt      <= '0;
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rd     <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rd     <= '0;
        end else begin
            if (p0_gnt) last <= 1'b0;
            if (p1_gnt) last <= 1'b1;

            // A locked grant that does not extend the current burst starts a new one.
            if (p1_gnt && p1_lock) begin
                st   <= BURST;
                bcnt <= hold ? bcnt + 8'd1 : 8'd1;
            end else begin
                st   <= ARB;
                bcnt <= '0;
            end

            p0_rvalid <= p0_gnt;
            p0_err    <= p0_gnt & bad;
            if (p0_gnt && bad)
                p0_rd <= '0;
            else if (p0_gnt && !p0_we)
                p0_rd <= mem_rd;

            p1_rvalid <= p1_gnt;
            p1_err    <= p1_gnt & bad;
            if (p1_gnt && bad)
                p1_rd <= '0;
            else if (p1_gnt && !p1_we)
                p1_rd <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, per-cycle reference model compare and
// directed vectors with hand-computed expectations.
module tb_dmem_arbiter;

    localparam int MEM_AW    = 14;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [31:0]       p0_adr, p0_wd, p1_adr, p1_wd;
    logic              p0_gnt, p0_rvalid, p0_err, p0_stall;
    logic              p1_gnt, p1_rvalid, p1_err;
    logic [31:0]       p0_rd, p1_rd;
    logic [MEM_AW-1:0] mem_a;
    logic              mem_we;
    logic [31:0]       mem_wd, mem_rd;

    logic [31:0] phys_mem  [0:DEPTH-1];
    logic [31:0] model_mem [0:DEPTH-1];

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    dmem_arbiter #(.MEM_AW(MEM_AW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wd(p0_wd),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rd(p0_rd), .p0_err(p0_err),
        .p0_stall(p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wd(p1_wd),
        .p1_lock(p1_lock),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rd(p1_rd), .p1_err(p1_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = phys_mem[mem_a];
    always @(negedge clk) if (mem_we) phys_mem[mem_a] <= mem_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected response registers and burst bookkeeping.
    bit          m_rv   [2];
    bit          m_err  [2];
    logic [31:0] m_rd   [2];
    int          m_last;
    bit          m_in_burst;
    int          m_beats;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 0; m_err[p] = 0; m_rd[p] = '0;
        end
        m_last = 1; m_in_burst = 0; m_beats = 0;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            int          win;
            bit          hold, ok, we;
            logic [31:0] adr, wd;
            int unsigned idx;
            win  = -1;
            hold = m_in_burst && p1_req && p1_lock && (m_beats < MAX_BURST);
            if (!rst) begin
                if (hold) win = 1;
                else if (p0_req && p1_req) win = (m_in_burst || m_last == 1) ? 0 : 1;
                else if (p0_req) win = 0;
                else if (p1_req) win = 1;
            end
            adr = (win == 1) ? p1_adr : p0_adr;
            wd  = (win == 1) ? p1_wd  : p0_wd;
            we  = (win == 1) ? p1_we  : p0_we;
            ok  = (adr % 4 == 0) && (adr < (32'd1 << (MEM_AW + 2)));
            idx = (adr / 4) % DEPTH;

            chk("m_p0_gnt", 32'(p0_gnt), 32'(win == 0));
            chk("m_p1_gnt", 32'(p1_gnt), 32'(win == 1));
            chk("m_p0_stall", 32'(p0_stall), 32'(p0_req && win != 0));
            chk("m_mem_we", 32'(mem_we), 32'(win >= 0 && we && ok));
            chk("m_mem_a", 32'(mem_a), idx);
            chk("m_mem_wd", mem_wd, wd);
            chk("m_p0_rvalid", 32'(p0_rvalid), 32'(m_rv[0]));
            chk("m_p0_err", 32'(p0_err), 32'(m_err[0]));
            chk("m_p0_rd", p0_rd, m_rd[0]);
            chk("m_p1_rvalid", 32'(p1_rvalid), 32'(m_rv[1]));
            chk("m_p1_err", 32'(p1_err), 32'(m_err[1]));
            chk("m_p1_rd", p1_rd, m_rd[1]);

            if (rst) begin
                model_reset();
            end else begin
                for (int p = 0; p < 2; p++) begin
                    m_rv[p]  = (win == p);
                    m_err[p] = (win == p) && !ok;
                end
                if (win >= 0) begin
                    if (!ok) m_rd[win] = '0;
                    else if (we) model_mem[idx] = wd;
                    else m_rd[win] = model_mem[idx];
                    m_last = win;
                end
                if (win == 1 && p1_lock) begin
                    m_beats    = hold ? m_beats + 1 : 1;
                    m_in_burst = 1;
                end else begin
                    m_beats    = 0;
                    m_in_burst = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 0; p1_req = 0; p1_lock = 0;
    endtask

    int exp_g1 [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    int exp_bc [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2};

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            phys_mem[i]  = '0;
            model_mem[i] = '0;
        end
        model_reset();
        rst = 1; idle();
        p0_we = 0; p1_we = 0; p0_adr = '0; p1_adr = '0; p0_wd = '0; p1_wd = '0;
        step();
        check_en = 1'b1;
        step();
        chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst_p1_rd", p1_rd, 32'd0);
        chk("rst_st", 32'(dut.st), 32'd0);
        chk("rst_bcnt", 32'(dut.bcnt), 32'd0);
        rst = 0;

        // Single write then read-back on port 0
        p0_req = 1; p0_we = 1; p0_adr = 32'h10; p0_wd = 32'hDEADBEEF;
        #2;
        chk("wr_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_a", 32'(mem_a), 32'd4);
        step();
        chk("wr_rvalid", 32'(p0_rvalid), 32'd1);
        chk("wr_err", 32'(p0_err), 32'd0);
        chk("wr_rd_held", p0_rd, 32'd0);
        p0_we = 0;
        step();
        p0_req = 0;
        chk("rd_p0_rd", p0_rd, 32'hDEADBEEF);
        chk("rd_rvalid", 32'(p0_rvalid), 32'd1);
        step();
        chk("idle_rvalid", 32'(p0_rvalid), 32'd0);

        // Round-robin alternation from reset
        rst = 1; step(); rst = 0;
        p0_req = 1; p0_adr = 32'h10; p1_req = 1; p1_we = 0; p1_adr = 32'h20;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("rr_p0_gnt", 32'(p0_gnt), 32'(i % 2 == 0));
            chk("rr_p0_stall", 32'(p0_stall), 32'(i % 2 == 1));
            step();
        end

        // Locked burst from port 1 with port 0 waiting
        p1_lock = 1; p1_we = 1; p1_adr = 32'h100; p1_wd = 32'hA000_0000;
        for (int c = 0; c < 12; c++) begin
            #2;
            chk("bu_p1_gnt", 32'(p1_gnt), 32'(exp_g1[c]));
            chk("bu_p0_gnt", 32'(p0_gnt), 32'(1 - exp_g1[c]));
            step();
            chk("bu_bcnt", 32'(dut.bcnt), 32'(exp_bc[c]));
            if (exp_g1[c] == 1) begin
                p1_adr = p1_adr + 32'd4;
                p1_wd  = p1_wd + 32'd1;
            end
        end
        idle();
        step();
        p0_req = 1; p0_adr = 32'h100;
        step();
        chk("bu_mem0", p0_rd, 32'hA000_0000);
        p0_adr = 32'h11C;
        step();
        p0_req = 0;
        chk("bu_mem7", p0_rd, 32'hA000_0007);

        // Error cases
        p1_req = 1; p1_we = 0; p1_adr = 32'h10;
        step();
        chk("e_p1_rd_pre", p1_rd, 32'hDEADBEEF);
        p1_we = 1; p1_adr = 32'h0001_0000; p1_wd = 32'h1234_5678;
        #2;
        chk("e_p1_gnt", 32'(p1_gnt), 32'd1);
        chk("e_mem_we", 32'(mem_we), 32'd0);
        step();
        p1_req = 0;
        chk("e_p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("e_p1_err", 32'(p1_err), 32'd1);
        chk("e_p1_rd", p1_rd, 32'd0);
        p0_req = 1; p0_adr = 32'h0;
        step();
        chk("e_mem0", p0_rd, 32'd0);
        chk("e_mem0_err", 32'(p0_err), 32'd0);
        p0_adr = 32'h6;
        step();
        p0_req = 0;
        chk("e_p0_err", 32'(p0_err), 32'd1);
        chk("e_p0_rvalid", 32'(p0_rvalid), 32'd1);

        // Reset during the 4th locked beat
        p1_req = 1; p1_lock = 1; p1_we = 1; p1_adr = 32'h200; p1_wd = 32'hB000_0000;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("rb_p1_gnt", 32'(p1_gnt), 32'd1);
            step();
            p1_adr = p1_adr + 32'd4;
            p1_wd  = p1_wd + 32'd1;
        end
        rst = 1;
        #2;
        chk("rb_gnt_rst", 32'(p1_gnt), 32'd0);
        chk("rb_we_rst", 32'(mem_we), 32'd0);
        step();
        rst = 0; idle();
        chk("rb_no_rvalid", 32'(p1_rvalid), 32'd0);
        p0_req = 1; p0_adr = 32'h20C;
        #2;
        chk("rb_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("rb_st", 32'(dut.st), 32'd0);
        step();
        chk("rb_unwritten", p0_rd, 32'd0);
        p0_adr = 32'h208;
        step();
        chk("rb_beat3", p0_rd, 32'hB000_0002);

        // Lock dropped on beat 3 with port 0 waiting
        p0_adr = 32'h10;
        p1_req = 1; p1_lock = 1; p1_we = 1; p1_adr = 32'h300; p1_wd = 32'hC000_0000;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("ld_p1_gnt", 32'(p1_gnt), 32'd1);
            step();
            p1_adr = p1_adr + 32'd4;
        end
        p1_lock = 0;
        #2;
        chk("ld_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("ld_p1_wait", 32'(p1_gnt), 32'd0);
        step();
        chk("ld_st", 32'(dut.st), 32'd0);
        p0_req = 0;
        #2;
        chk("ld_p1_after", 32'(p1_gnt), 32'd1);
        step();
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the 64 KB data memory (14-bit word address, asynchronous read, write committed on the falling edge of `clk`). It shares that single memory port between the core's load/store path (port 0) and a loader/DMA master (port 1), with round-robin arbitration and bounded locked bursts for port 1. It also performs address range and alignment checks and returns registered read data with a valid/error pulse.

## Interface
- `MEM_AW`, 14: word-address width of the memory; the byte range is 0 .. 2^(MEM_AW+2)-1.
- `MAX_BURST`, 8: maximum consecutive locked grants to port 1 (range 1..255).
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `pN_req` input 1 (N=0,1): access request; held until `pN_gnt`.
- `pN_we` input 1: 1 = word write, 0 = word read.
- `pN_adr` input 32: byte address.
- `pN_wd` input 32: write data.
- `p1_lock` input 1: port 1 requests to keep ownership for the following beat.
- `pN_gnt` output 1: combinational grant; the access is taken in this cycle.
- `pN_rvalid` output 1: one-cycle pulse, cycle after grant (reads and writes).
- `pN_rd` output 32: registered read data; holds its value until the next rvalid.
- `pN_err` output 1: pulses with `pN_rvalid` if the access was rejected.
- `p0_stall` output 1: `p0_req & ~p0_gnt`; freezes the core.
- `mem_a` output MEM_AW: word address to the memory.
- `mem_we` output 1: memory write enable.
- `mem_wd` output 32: memory write data.
- `mem_rd` input 32: asynchronous memory read data.

## Operation
- State: `st` ∈ {ARB, BURST}, `last` (last port granted), `bcnt` (8 bits).
- Reset values: `st`=ARB, `last`=1, `bcnt`=0, all `pN_rvalid`/`pN_err`=0, `pN_rd`=0. While `rst`=1: both grants=0, `mem_we`=0, `p0_stall`=`p0_req`.
- ARB grant: only one requester → that one. Both → the port ≠ `last`.
- BURST grant: if `p1_req & p1_lock` is high and `bcnt` < MAX_BURST, port 1 is granted unconditionally. Otherwise use the ARB rule, with `last` forced to 1 for this decision.
- Transitions at posedge:
  - ARB → BURST when port 1 is granted with `p1_lock`=1; `bcnt` ← 1.
  - BURST, port 1 granted with lock, `bcnt` < MAX_BURST: stay; `bcnt` ← `bcnt`+1.
  - BURST, any other cycle: → ARB, `bcnt` ← 0. If that cycle granted port 1 with lock, ARB → BURST applies in the same evaluation and `bcnt` ← 1.
- `last` updates to the granted port on every grant.
- Memory drive: `mem_a` = winner `adr[MEM_AW+1:2]`, and `mem_wd` = winner `wd`. With no grant, port 0 fields are driven and `mem_we`=0.
- Validity check: the access is rejected if `adr[1:0]`≠0 or `adr[31:MEM_AW+2]`≠0.
  - A rejected access still consumes its grant.
  - `mem_we` is forced to 0.
  - Next cycle: `rvalid`=1, `err`=1, `rd`←0.
- Valid read: `pN_rd` ← `mem_rd` at the posedge ending the grant cycle; `rvalid`=1, `err`=0 in the next cycle.
- Valid write: `mem_we`=1 during the grant cycle. Next cycle: `rvalid`=1, `err`=0, and `rd` unchanged.

## Timing
- Grant and memory drive are combinational in the request cycle, so a lone request has zero wait.
- Response latency is exactly 1 cycle after the grant, for both ports.
- The memory write lands on the falling edge inside the grant cycle. A read of the same word in any later cycle returns the new data.
- At most one access per cycle. Throughput is 1 access/cycle.
- Port 0 worst-case wait is MAX_BURST cycles during a port 1 burst, and 1 cycle otherwise.
- Dropping `p1_req` mid-burst ends the burst that cycle; port 0 can be granted in the same cycle.
- `rst` asserted in a grant cycle: no write occurs, and no `rvalid` is produced in the next cycle.

## Test plan
- Reset then single requests:
  - `p0` write 0x0000_0010 ← 0xDEADBEEF → `p0_gnt` same cycle, `mem_we`=1, `mem_a`=4, `p0_rvalid`=1 next cycle, `p0_err`=0.
  - Then `p0` read 0x10 → `p0_rd`=0xDEADBEEF one cycle after grant.
- Both requesting continuously, no lock → grants alternate p0, p1, p0, p1, …, with p0 first after reset. `p0_stall`=1 exactly in the cycles p1 owns.
- p1 locked burst, MAX_BURST=8, with p0 requesting throughout:
  - p1 is granted 8 consecutive cycles, then p0 is granted once, then p1 re-enters the burst.
  - `bcnt` observed as 1..8.
- Error cases:
  - p1 write to 0x0001_0000 → grant, `mem_we`=0, and next cycle `p1_err`=1, `p1_rd`=0. A subsequent read of 0x0 is unchanged.
  - p0 read at 0x0000_0006 → `p0_err`=1.
- Reset mid-burst: assert `rst` in the 4th locked beat of a p1 write →
  - that beat is not written and no `rvalid` follows;
  - after reset, a lone p0 request is granted immediately and `st`=ARB.
- Lock drop: p1 lock deasserted on beat 3 with p0 waiting → p0 granted on the following cycle and `st` returns to ARB.
